// File: rtl/pwm_capture.sv
// Servo PWM decoder: measures the high time of a synchronized pulse train and
// converts it to an angle (0..180) using an incremental prescaler, no divider.
module pwm_capture #(
  parameter int BASE_CYCLES    = 50000,
  parameter int CYC_PER_DEG    = 277,
  parameter int MIN_CYCLES     = 25000,
  parameter int MAX_CYCLES     = 125000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic [16:0] width,
  output logic        valid,
  output logic        err,
  output logic        lost
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(CYC_PER_DEG + 1);

  localparam logic [16:0]   BASE_W  = 17'(BASE_CYCLES);
  localparam logic [16:0]   MIN_W   = 17'(MIN_CYCLES);
  localparam logic [16:0]   MAX_W   = 17'(MAX_CYCLES);
  localparam logic [PW-1:0] PRE_TOP = PW'(CYC_PER_DEG - 1);
  localparam logic [TW-1:0] TMO_TOP = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    DEG_TOP = 8'd180;

  typedef enum logic [1:0] {ARM, WAIT_RISE, MEASURE} state_t;

  function automatic logic [16:0] sat_inc17(input logic [16:0] v);
    return (v == 17'h1ffff) ? v : v + 17'd1;
  endfunction

  function automatic logic [TW-1:0] sat_inc_tmo(input logic [TW-1:0] v);
    return (v == TMO_TOP) ? v : v + TW'(1);
  endfunction

  state_t        state_q, state_d;
  logic          sync1_q, pwm_s_q, pwm_d_q;
  logic [1:0]    fill_q, fill_d;
  logic [16:0]   cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    deg_q, deg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    angle_q, angle_d;
  logic [16:0]   width_q, width_d;
  logic          valid_q, valid_d, err_q, err_d, lost_q, lost_d;
  logic          rise, fall;

  assign rise    = pwm_s_q & ~pwm_d_q;
  assign fall    = ~pwm_s_q & pwm_d_q;
  assign cnt_inc = sat_inc17(cnt_q);

  always_comb begin
    state_d = state_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    deg_d   = deg_q;
    angle_d = angle_q;
    width_d = width_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      // fill_q keeps ARM from trusting the zeroed synchronizer right after reset
      ARM: if (fill_q == 2'd2 && !pwm_s_q) state_d = WAIT_RISE;
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = 17'd1;  // the rising-edge cycle is itself the first high cycle
          pre_d   = '0;
          deg_d   = '0;
        end
      end
      MEASURE: begin
        if (cnt_q > MAX_W) begin
          err_d   = 1'b1;
          state_d = ARM;
        end else if (fall) begin
          if (cnt_q >= MIN_W) begin
            valid_d = 1'b1;
            angle_d = deg_q;
            width_d = cnt_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = WAIT_RISE;
        end else if (pwm_s_q) begin
          cnt_d = cnt_inc;
          // one degree for every CYC_PER_DEG cycles beyond BASE_CYCLES
          if (cnt_inc > BASE_W) begin
            if (pre_q == PRE_TOP) begin
              pre_d = '0;
              if (deg_q != DEG_TOP) deg_d = deg_q + 8'd1;
            end else begin
              pre_d = pre_q + PW'(1);
            end
          end
        end
      end
      default: state_d = ARM;
    endcase

    tmo_d = rise ? '0 : sat_inc_tmo(tmo_q);
    if (valid_d)                                lost_d = 1'b0;
    else if (tmo_q != TMO_TOP && tmo_d == TMO_TOP) lost_d = 1'b1;
    else                                        lost_d = lost_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARM;
      sync1_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
      fill_q  <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      deg_q   <= '0;
      tmo_q   <= '0;
      angle_q <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sync1_q <= pwm_in;
      pwm_s_q <= sync1_q;
      pwm_d_q <= pwm_s_q;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      deg_q   <= deg_d;
      tmo_q   <= tmo_d;
      angle_q <= angle_d;
      width_q <= width_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign angle = angle_q;
  assign width = width_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with scaled-down timing parameters; a
// scoreboard queue holds expected strobes and a negedge monitor checks them.
module tb_pwm_capture;

  localparam int BASE = 500;
  localparam int CPD  = 5;
  localparam int MINC = 250;
  localparam int MAXC = 1600;
  localparam int TMO  = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [7:0]  angle;
  logic [16:0] width;
  logic        valid, err, lost;

  pwm_capture #(
    .BASE_CYCLES(BASE), .CYC_PER_DEG(CPD), .MIN_CYCLES(MINC),
    .MAX_CYCLES(MAXC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .angle(angle), .width(width),
    .valid(valid), .err(err), .lost(lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  ang;
    logic [16:0] wid;
    bit          chk_lat;
    int          fall_c;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_ang = '0;
  logic [16:0] exp_wid = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && err) check("valid_err_exclusive", 1, 0);
      if (valid || err) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, valid, err}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_kind_err", int'(err), int'(e.is_err));
          check("angle", int'(angle), int'(e.ang));
          check("width", int'(width), int'(e.wid));
          if (valid) check("lost_at_valid", int'(lost), 0);
          if (e.chk_lat) check("fall_to_strobe_edges", cyc - e.fall_c, 3);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // High for h cycles then low for l cycles; ang is the hand-computed angle.
  task automatic pulse(input int h, input int l, input int ang);
    exp_t e;
    if (h > MAXC) begin
      e = '{is_err: 1'b1, ang: exp_ang, wid: exp_wid, chk_lat: 1'b0, fall_c: 0};
      sb.push_back(e);
    end
    pwm_in = 1'b1;
    wait_cyc(h);
    pwm_in = 1'b0;
    if (h < MINC) begin
      e = '{is_err: 1'b1, ang: exp_ang, wid: exp_wid, chk_lat: 1'b1, fall_c: cyc};
      sb.push_back(e);
    end else if (h <= MAXC) begin
      exp_ang = 8'(ang);
      exp_wid = 17'(h);
      e = '{is_err: 1'b0, ang: exp_ang, wid: exp_wid, chk_lat: 1'b1, fall_c: cyc};
      sb.push_back(e);
    end
    wait_cyc(l);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    check("rst_angle", int'(angle), 0);
    check("rst_width", int'(width), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_lost", int'(lost), 1);
    rst = 1'b0;
    wait_cyc(5);

    pulse(950, 2050, 90);
    check("lost_after_first_valid", int'(lost), 0);
    pulse(950, 2050, 90);
    pulse(1400, 1600, 180);
    pulse(1500, 1500, 180);
    pulse(500, 2500, 0);
    pulse(505, 2495, 1);
    pulse(504, 2496, 0);
    pulse(250, 2750, 0);
    pulse(1600, 1400, 180);
    pulse(100, 2900, 0);
    pulse(1700, 1300, 0);
    pulse(950, 2050, 90);
    check("lost_during_traffic", int'(lost), 0);

    // Silence long enough for the timeout to expire.
    wait_cyc(3200);
    check("lost_after_timeout", int'(lost), 1);
    check("angle_hold_timeout", int'(angle), 90);
    check("width_hold_timeout", int'(width), 950);
    pulse(505, 2495, 1);
    check("lost_cleared_by_valid", int'(lost), 0);

    // Reset in the middle of a pulse; that pulse must be ignored.
    pwm_in = 1'b1;
    wait_cyc(100);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    exp_ang = '0;
    exp_wid = '0;
    check("midrst_angle", int'(angle), 0);
    check("midrst_lost", int'(lost), 1);
    wait_cyc(900);
    pwm_in = 1'b0;
    wait_cyc(2000);
    check("midrst_width_unchanged", int'(width), 0);
    pulse(950, 2050, 90);

    wait_cyc(10);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter BASE_CYCLES, 50000, high-time in clk cycles that maps to angle 0 (1 ms at 50 MHz) SHALL be provided.
REQ-002 Parameter CYC_PER_DEG, 277, clk cycles per degree above BASE_CYCLES SHALL be provided.
REQ-003 Parameter MIN_CYCLES, 25000, shortest accepted pulse (0.5 ms) SHALL be provided.
REQ-004 Parameter MAX_CYCLES, 125000, longest accepted pulse (2.5 ms) SHALL be provided.
REQ-005 Parameter TIMEOUT_CYCLES, 1500000, cycles without a rising edge before signal loss (30 ms) SHALL be provided.
REQ-006 Port clk  input  1  system clock (50 MHz) SHALL be provided.
REQ-007 Port rst  input  1  reset, synchronous, active-high SHALL be provided.
REQ-008 Port pwm_in  input  1  asynchronous servo PWM pulse train SHALL be provided.
REQ-009 Port angle  output  8  last decoded angle, 0..180 degrees SHALL be provided.
REQ-010 Port width  output  17  last accepted high-time in clk cycles SHALL be provided.
REQ-011 Port valid  output  1  one-cycle strobe on each new angle/width SHALL be provided.
REQ-012 Port err  output  1  one-cycle strobe on a rejected pulse SHALL be provided.
REQ-013 Port lost  output  1  level, no rising edge within TIMEOUT_CYCLES SHALL be provided.

Function
REQ-014 pwm_in SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized signal (pwm_s) and its 1-cycle delayed copy.
REQ-015 FSM states SHALL be ARM, WAIT_RISE, MEASURE.
REQ-016 ARM: waits for pwm_s=0, then goes to WAIT_RISE; a pulse already high at entry SHALL never be measured.
REQ-017 WAIT_RISE: on a synchronized rising edge, clear width counter, degree counter and prescaler, then go to MEASURE.
REQ-018 MEASURE: the width counter SHALL increment once per cycle while pwm_s=1, so the final count equals the number of cycles pwm_in was high.
REQ-019 Degree count SHALL equal floor((W-BASE_CYCLES)/CYC_PER_DEG) for W>=BASE_CYCLES, 0 for W<BASE_CYCLES, and saturate at 180.
REQ-020 The degree count SHALL be built incrementally from a prescaler; no divider or multiplier is permitted.
REQ-021 On a synchronized falling edge with MIN_CYCLES<=W<=MAX_CYCLES: latch angle and width, pulse valid for 1 cycle, go to WAIT_RISE.
REQ-022 These updates SHALL occur on the 3rd rising clk edge after pwm_in falls.
REQ-023 On a falling edge with W<MIN_CYCLES: pulse err, leave angle and width unchanged, go to WAIT_RISE.
REQ-024 While high, once W exceeds MAX_CYCLES: pulse err on the next cycle, leave angle and width unchanged, go to ARM.
REQ-025 valid and err SHALL never be asserted in the same cycle.
REQ-026 Width counter SHALL saturate and never wrap.
REQ-027 A timeout counter SHALL clear on every synchronized rising edge and saturate at TIMEOUT_CYCLES.
REQ-028 lost SHALL assert when the timeout counter reaches TIMEOUT_CYCLES and clear on the next valid strobe.
REQ-029 If a timeout and a valid occur in the same cycle, valid SHALL win and lost SHALL be 0.

Reset
REQ-030 On clk edge with rst=1: state=ARM, angle=0, width=0, valid=0, err=0, lost=1, all counters and synchronizer flops=0.
REQ-031 rst asserted mid-pulse SHALL abort the measurement with no valid or err strobe; after release the block SHALL wait for pwm_s=0 before arming.

Verification
REQ-032 Reset, then a 75000-cycle high pulse in a 1000000-cycle period -> valid once per period, angle=90, width=75000, lost falls to 0 at the first valid.
REQ-033 100000-cycle pulse -> angle=180; 110000-cycle pulse -> angle=180 (saturated).
REQ-034 Pulses of 50000 and 50277 cycles -> angle=0 and angle=1; valid exactly 3 clk edges after pwm_in falls.
REQ-035 Pulse of 10000 cycles -> err pulse, no valid, angle unchanged; pulse of 130000 cycles -> err one cycle after count passes 125000, FSM in ARM, next legal pulse decodes normally.
REQ-036 pwm_in held low 1500000 cycles after traffic -> lost=1, angle holds the last value; rst released while pwm_in=1 -> that pulse ignored, following pulse measured.
